// File: rtl/vga_sync_controller.sv
// Vertical raster sequencer: registered hsync/vsync/video_on from h_count, with per-line prefetch req/ack.
// `VGA_UNDERRUN_BLANK_EN: a row whose prefetch missed its deadline is shown blank.
module vga_sync_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] h_count,
  input  logic       new_line,
  input  logic       line_ack,
  input  logic       underrun_clr,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [9:0] v_count,
  output logic       frame_start,
  output logic       line_req,
  output logic [9:0] line_req_y,
  output logic       underrun,
  output logic       running
);
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;

  if (H_ACTIVE + H_FP + H_PULSE + H_BP > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_sync_controller: raster totals exceed 10-bit counters");
  end

  localparam logic [9:0] C_HA    = 10'(H_ACTIVE);
  localparam logic [9:0] C_HS0   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS1   = 10'(H_ACTIVE + H_FP + H_PULSE);
  localparam logic [9:0] C_VA    = 10'(V_ACTIVE);
  localparam logic [9:0] C_VS0   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VB0   = 10'(V_ACTIVE + V_FP + V_PULSE);
  localparam logic [9:0] C_VLAST = 10'(V_TOTAL - 1);

  typedef enum logic [2:0] {S_IDLE, S_V_ACT, S_V_FRONT, S_V_SYNC, S_V_BACK} state_t;

  state_t     r_state;
  logic [9:0] r_vcnt;
  logic       r_armed;
  logic       r_hsync, r_vsync, r_video_on, r_frame_start;
  logic [9:0] r_pixel_x, r_pixel_y, r_line_req_y;
  logic       r_line_req, r_underrun;

  logic [9:0] w_next_v;
  logic       w_miss;
  logic       w_fetch;
  logic       w_blank;

  function automatic state_t line_state(input logic [9:0] v);
    if (v < C_VA)       return S_V_ACT;
    else if (v < C_VS0) return S_V_FRONT;
    else if (v < C_VB0) return S_V_SYNC;
    else                return S_V_BACK;
  endfunction

  assign w_next_v = (r_vcnt == C_VLAST) ? 10'd0 : r_vcnt + 10'd1;
  // A request still open at the line boundary has missed; a same-cycle ack rescues it.
  assign w_miss   = r_line_req & new_line & ~line_ack;
  assign w_fetch  = (r_state != S_IDLE) && (h_count == C_HA) && (w_next_v < C_VA);

`ifdef VGA_UNDERRUN_BLANK_EN
  logic r_blank;
  always_ff @(posedge clk) begin
    if (rst)           r_blank <= 1'b0;
    else if (new_line) r_blank <= w_miss;
  end
  assign w_blank = r_blank;
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_vcnt        <= 10'd0;
      r_armed       <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_pixel_x     <= 10'd0;
      r_pixel_y     <= 10'd0;
      r_frame_start <= 1'b0;
      r_line_req    <= 1'b0;
      r_line_req_y  <= 10'd0;
      r_underrun    <= 1'b0;
    end else begin
      r_hsync       <= !((r_state != S_IDLE) && (h_count >= C_HS0) && (h_count < C_HS1));
      r_vsync       <= (r_state != S_V_SYNC);
      r_video_on    <= (r_state == S_V_ACT) && (h_count < C_HA) && !w_blank;
      r_pixel_x     <= h_count;
      r_pixel_y     <= r_vcnt;
      r_frame_start <= (r_state == S_V_ACT) && (r_vcnt == 10'd0) && (h_count == 10'd0);

      if (w_miss)            r_underrun <= 1'b1;
      else if (underrun_clr) r_underrun <= 1'b0;

      if (w_miss || (r_line_req && line_ack)) r_line_req <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_armed <= r_armed | enable;
          // Start one line early in the last back-porch line so row 0 is prefetched in time.
          if (new_line && (r_armed || enable)) begin
            r_state      <= S_V_BACK;
            r_vcnt       <= C_VLAST;
            r_line_req   <= 1'b1;
            r_line_req_y <= 10'd0;
            r_armed      <= 1'b0;
          end
        end
        default: begin
          if (new_line) begin
            if (r_vcnt == C_VLAST && !enable) begin
              r_state <= S_IDLE;
              r_vcnt  <= 10'd0;
            end else begin
              r_state <= line_state(w_next_v);
              r_vcnt  <= w_next_v;
            end
          end
        end
      endcase

      if (w_fetch) begin
        r_line_req   <= 1'b1;
        r_line_req_y <= w_next_v;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign v_count     = r_vcnt;
  assign frame_start = r_frame_start;
  assign line_req    = r_line_req;
  assign line_req_y  = r_line_req_y;
  assign underrun    = r_underrun;
  assign running     = (r_state != S_IDLE);

endmodule

// File: tb/tb_vga_sync_controller.sv
// Randomized bench for vga_sync_controller on a shrunken raster, checked against a line/pixel arithmetic model.
module tb_vga_sync_controller;
  localparam int HA = 16, HF = 4, HP = 6, HB = 6;
  localparam int VA = 8,  VF = 2, VP = 2, VB = 3;
  localparam int HT = HA + HF + HP + HB;
  localparam int VT = VA + VF + VP + VB;

  logic       clk = 1'b0;
  logic       rst, enable, new_line, line_ack, underrun_clr;
  logic [9:0] h_count;
  logic       hsync, vsync, video_on, frame_start, line_req, underrun, running;
  logic [9:0] pixel_x, pixel_y, v_count, line_req_y;

  vga_sync_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_PULSE(VP), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .h_count(h_count), .new_line(new_line),
    .line_ack(line_ack), .underrun_clr(underrun_clr),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .v_count(v_count), .frame_start(frame_start), .line_req(line_req), .line_req_y(line_req_y),
    .underrun(underrun), .running(running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Model: raster position as plain integers plus the outstanding request.
  bit m_run, m_armed, m_req, m_under, m_blank;
  int m_v, m_ry;
  bit e_hs, e_vs, e_vid, e_fs;
  int e_px, e_py;

  task automatic model_step();
    bit miss, fetch;
    int nv;
    if (rst) begin
      m_run = 0; m_armed = 0; m_req = 0; m_under = 0; m_blank = 0; m_v = 0; m_ry = 0;
      e_hs = 1; e_vs = 1; e_vid = 0; e_fs = 0; e_px = 0; e_py = 0;
    end else begin
      nv    = (m_v + 1) % VT;
      miss  = m_req && new_line && !line_ack;
      fetch = m_run && (h_count == HA) && (nv < VA);
      e_hs  = !(m_run && h_count >= HA + HF && h_count < HA + HF + HP);
      e_vs  = !(m_run && m_v >= VA + VF && m_v < VA + VF + VP);
`ifdef VGA_UNDERRUN_BLANK_EN
      e_vid = m_run && m_v < VA && h_count < HA && !m_blank;
`else
      e_vid = m_run && m_v < VA && h_count < HA;
`endif
      e_px  = int'(h_count);
      e_py  = m_v;
      e_fs  = m_run && m_v == 0 && h_count == 0;
      if (miss) m_under = 1;
      else if (underrun_clr) m_under = 0;
      if (miss || (m_req && line_ack)) m_req = 0;
      if (new_line) m_blank = miss;
      if (!m_run) begin
        m_armed = m_armed || enable;
        if (new_line && m_armed) begin
          m_run = 1; m_v = VT - 1; m_req = 1; m_ry = 0; m_armed = 0;
        end
      end else if (new_line) begin
        if (m_v == VT - 1 && !enable) begin m_run = 0; m_v = 0; end
        else m_v = nv;
      end
      if (fetch) begin m_req = 1; m_ry = nv; end
    end
  endtask

  int  ack_k_mode = 5;   // fixed ack delay, or -1 for random
  bit  ack_noise  = 0;
  int  req_age = 0, ack_k = 0;
  bit  period_chk = 0;
  int  cyc = 0, last_fs = -1, hs_low = 0, vs_low = 0, fs_seen = 0;

  task automatic run_cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("hsync", hsync, e_hs);
    check("vsync", vsync, e_vs);
    check("video_on", video_on, e_vid);
    check("pixel_x", pixel_x, e_px);
    if (e_vid) check("pixel_y", pixel_y, e_py);
    check("v_count", v_count, m_v);
    check("frame_start", frame_start, e_fs);
    check("line_req", line_req, m_req);
    if (m_req) check("line_req_y", line_req_y, m_ry);
    check("underrun", underrun, m_under);
    check("running", running, m_run);
    if (frame_start) fs_seen++;
    if (period_chk) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_start) begin
        if (last_fs >= 0) begin
          check("fs_period", cyc - last_fs, HT * VT);
          check("hs_low_per_frame", hs_low, HP * VT);
          check("vs_low_per_frame", vs_low, VP * HT);
          check("no_underrun", underrun, 0);
        end
        last_fs = cyc; hs_low = 0; vs_low = 0;
      end
    end
    // Next-cycle stimulus: free-running h counter and the framebuffer responder.
    h_count  = (h_count == 10'(HT - 1)) ? 10'd0 : h_count + 10'd1;
    new_line = (h_count == 10'(HT - 1));
    if (m_req) begin
      req_age++;
      if (req_age == 1) ack_k = (ack_k_mode >= 0) ? ack_k_mode : int'($urandom_range(0, 20));
    end else req_age = 0;
    line_ack = m_req && (req_age == ack_k + 1);
    if (!m_req && ack_noise && $urandom_range(0, 15) == 0) line_ack = 1;
  endtask

  initial begin
    rst = 1; enable = 0; line_ack = 0; underrun_clr = 0; h_count = 10'd5; new_line = 0;
    run_cycle();
    run_cycle();
    rst = 0;
    check("rst_running", running, 0);

    // Steady run, ack 5 cycles after each request.
    enable = 1; period_chk = 1;
    repeat (4 * HT * VT) run_cycle();
    check("fs_count_steady", fs_seen >= 3, 1);
    period_chk = 0;

    // Randomized: ack delays straddling the deadline, spurious acks, clears, enable toggles.
    ack_k_mode = -1; ack_noise = 1;
    repeat (20 * HT * VT) begin
      underrun_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1999) == 0) enable = ~enable;
      run_cycle();
    end
    underrun_clr = 0; enable = 1; ack_noise = 0;

    // Withheld ack forces an underrun, then a clear.
    ack_k_mode = 99;
    for (int i = 0; i < 4 * HT * VT && !m_under; i++) run_cycle();
    check("underrun_seen", underrun, 1);
    repeat (HT) run_cycle();
    underrun_clr = 1; run_cycle(); underrun_clr = 0;
    check("underrun_cleared", underrun, 0);

    // Ack exactly on the new_line cycle never underruns.
    ack_k_mode = 14;
    repeat (2 * HT * VT) run_cycle();
    check("coincident_ack_no_underrun", underrun, 0);
    ack_k_mode = 5;

    // Drop enable mid-frame: frame completes, then idle with syncs high.
    for (int i = 0; i < 2 * HT * VT && !(m_run && m_v == 3); i++) run_cycle();
    check("reach_line3", m_v, 3);
    enable = 0;
    for (int i = 0; i < 2 * HT * VT && m_run; i++) run_cycle();
    check("stopped", running, 0);
    fs_seen = 0;
    repeat (2 * HT * VT) run_cycle();
    check("no_fs_when_idle", fs_seen, 0);
    check("idle_vsync", vsync, 1);
    check("idle_hsync", hsync, 1);

    // Reset during vertical sync, and again with a request outstanding.
    enable = 1;
    for (int i = 0; i < 3 * HT * VT && !(m_run && m_v == VA + VF); i++) run_cycle();
    check("reach_vsync", m_v, VA + VF);
    rst = 1; run_cycle(); rst = 0;
    check("rst_vsync", vsync, 1);
    ack_k_mode = 99;
    for (int i = 0; i < 3 * HT * VT && !m_req; i++) run_cycle();
    check("req_pending", line_req, 1);
    rst = 1; run_cycle(); rst = 0;
    check("rst_drops_req", line_req, 0);
    ack_k_mode = 5;
    repeat (2 * HT * VT) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_sync_controller.md
# vga_sync_controller

Sequences the VGA raster around the free-running horizontal pixel counter. It consumes the counter's `h_count` and `new_line` outputs and runs the vertical line state machine. It generates registered hsync/vsync/video-enable and a per-line framebuffer prefetch request with a req/ack handshake. It sits between the horizontal counter and the framebuffer/pixel pipeline and is the single owner of raster sequencing.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_PULSE`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch lines
- `V_PULSE`, 2, vsync width in lines
- `V_BP`, 33, vertical back porch lines

Ports:
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run request; raster starts and stops only on frame boundaries.
- `h_count` in 10: horizontal position, 0..H_total-1.
- `new_line` in 1: one-cycle pulse, high during the cycle where `h_count == H_total-1`.
- `line_ack` in 1: framebuffer has loaded the requested row.
- `underrun_clr` in 1: clears the sticky underrun flag.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `video_on` out 1: pixel is visible.
- `pixel_x` out 10: column of the current pixel.
- `pixel_y` out 10: row of the current pixel.
- `v_count` out 10: current line, 0..V_total-1.
- `frame_start` out 1: one-cycle pulse at the first pixel of line 0.
- `line_req` out 1: prefetch request, level signal.
- `line_req_y` out 10: row being requested; stable while `line_req` is high.
- `underrun` out 1: sticky flag, prefetch missed its deadline.
- `running` out 1: raster active, i.e. not in IDLE.

## Operation
- `H_total = H_ACTIVE+H_FP+H_PULSE+H_BP`. `V_total` is defined the same way from the V parameters. All widths are 10 bits; totals must not exceed 1024.
- States: IDLE, V_ACT, V_FRONT, V_SYNC, V_BACK. Transitions happen only on clock edges where `new_line == 1`.
- IDLE:
  - `v_count=0`, `hsync=vsync=1`, `video_on=0`, `line_req=0`.
  - When `enable` is high, the controller arms. On the next `new_line` it issues `line_req` for row 0 and enters V_BACK at its last line (`v_count=V_total-1`). The following `new_line` enters V_ACT with `v_count=0`.
- `v_count` increments on each `new_line` and wraps from V_total-1 to 0.
  - V_ACT holds for `v_count` 0..V_ACTIVE-1.
  - V_FRONT, V_SYNC and V_BACK follow the parameter ranges in order.
- At the wrap from V_BACK to line 0: if `enable` is low, go to IDLE; otherwise go to V_ACT.
- `hsync` is low while `H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_PULSE`, in every non-IDLE state.
- `vsync` is low in V_SYNC only.
- `video_on = (h_count < H_ACTIVE) && state==V_ACT`.
- `pixel_x = h_count`. `pixel_y = v_count`. Both are valid only when `video_on` is high.
- Prefetch:
  - When `h_count == H_ACTIVE` and the next line, `(v_count+1) mod V_total`, is below V_ACTIVE, raise `line_req` and set `line_req_y` to that row.
  - `line_req` stays high until `line_ack` is sampled high, and drops the cycle after.
  - `line_ack` sampled while `line_req` is low is ignored.
- Deadline:
  - If `new_line` arrives while `line_req` is still high, set `underrun`, drop `line_req`, and abandon that row.
  - If `line_ack` and `new_line` arrive in the same cycle, the ack wins and no underrun is raised.
- `underrun` is cleared only by `rst` or `underrun_clr`. If `underrun_clr` coincides with a new underrun, the set wins.
- `frame_start` is high for one cycle when the state is V_ACT and `v_count==0` and `h_count==0` (registered).

## Timing
- All outputs are registered, with 1-cycle latency from `h_count`/`v_count`. An output seen at cycle n reflects `h_count` from cycle n-1.
- Reset values: `hsync=1`, `vsync=1`, `video_on=0`, `pixel_x=0`, `pixel_y=0`, `v_count=0`, `frame_start=0`, `line_req=0`, `line_req_y=0`, `underrun=0`, `running=0`, state=IDLE.
- `rst` mid-frame: everything returns to reset values at the next edge, including dropping any pending `line_req`.
- `enable` deasserted mid-frame: the current frame completes, then the block returns to IDLE.
- `enable` reasserted before the frame wrap: no effect; the block keeps running.

## Configuration
- `VGA_UNDERRUN_BLANK_EN` defined: a row whose prefetch underran is displayed blank, with `video_on` forced low for that whole line. Sync timing is unaffected.
- Not defined: an underrun only sets the `underrun` flag; `video_on` follows normal timing.

## Test plan
- Reset, `enable=1`, default parameters, ack returned 5 cycles after each request:
  - `frame_start` pulses every 420000 cycles.
  - `hsync` is low for 96 cycles per line.
  - `vsync` is low for 1600 cycles.
  - `underrun` stays 0.
- Prefetch timing: `line_req` rises 1 cycle after `h_count==640` with `line_req_y=v_count+1`. On line 524, `line_req_y=0`. No request is issued on lines 479..523.
- Ack withheld past `new_line`:
  - `underrun=1`, `line_req` drops.
  - With `VGA_UNDERRUN_BLANK_EN`, `video_on=0` for that row.
  - `underrun_clr` then clears the flag.
- `line_ack` coincident with `new_line`: no underrun.
- `enable` dropped at line 100: the frame finishes, `running` falls after line 524, `vsync`/`hsync` are held high, and no further `frame_start` occurs.
- `rst` pulsed during V_SYNC with `line_req` pending: all outputs return to reset values the next cycle.
